// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared PC-select encodings, bubble word and fetch FSM states
package if_fetch_stage_pkg;
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [31:0] NOP = 32'h0000_0000;
  typedef enum logic [1:0] {FETCH, DRAIN, BUF} state_t;
  function automatic logic is_redirect(input logic [1:0] sel);
    return sel == PC_BR || sel == PC_JMP;
  endfunction
endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush-over-stall priority
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);
  // flush beats stall; otherwise load a word or insert a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instr <= NOP_INSTR;
      ifid_pc_plus4 <= 32'h0;
      ifid_valid <= 1'b0;
    end else if (flush) begin
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_instr <= load ? instr : NOP_INSTR;
      ifid_pc_plus4 <= load ? pc_plus4 : ifid_pc_plus4;
      ifid_valid <= load;
    end
  end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, variable-latency imem fetch FSM and IF/ID register
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic        clear_ifid,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);
  state_t state, state_n;
  logic [31:0] pc, pc_n, saved, saved_n, buf_instr, buf_pc4, pc4, target, ld_instr, ld_pc4;
  logic redirect, load, buf_wr;
  assign redirect = is_redirect(pc_src);
  assign target = pc_src == PC_JMP ? jump_target : branch_target;
  assign pc4 = pc + 32'd4;
  assign imem_req = !rst && state != BUF;
  assign imem_addr = pc;
  assign ld_instr = state == BUF ? buf_instr : imem_rdata;
  assign ld_pc4 = state == BUF ? buf_pc4 : pc4;
  // next PC / state; DRAIN keeps the old address until the in-flight word lands
  always_comb begin
    state_n = state;
    pc_n = pc;
    saved_n = saved;
    load = 1'b0;
    buf_wr = 1'b0;
    if (state == FETCH) begin
      if (imem_ready) begin
        pc_n = redirect ? target : pc4;
        load = !redirect && !stall;
        buf_wr = !redirect && stall;
        state_n = buf_wr ? BUF : FETCH;
      end else if (redirect) begin
        saved_n = target;
        state_n = DRAIN;
      end
    end else if (state == DRAIN) begin
      saved_n = redirect ? target : saved;
      pc_n = imem_ready ? saved_n : pc;
      state_n = imem_ready ? FETCH : DRAIN;
    end else begin
      pc_n = redirect ? target : pc;
      load = !redirect && !stall;
      state_n = (redirect || !stall) ? FETCH : BUF;
    end
  end
  // state, PC and one-entry holding buffer for words returned under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      saved <= RESET_PC;
      buf_instr <= NOP_INSTR;
      buf_pc4 <= 32'h0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      saved <= saved_n;
      if (buf_wr) begin
        buf_instr <= imem_rdata;
        buf_pc4 <= pc4;
      end
    end
  end
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk(clk),
    .rst(rst),
    .flush(clear_ifid),
    .stall(stall),
    .load(load),
    .instr(ld_instr),
    .pc_plus4(ld_pc4),
    .ifid_instr(ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid)
  );
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed + random checks of the fetch stage against a transaction-level model
module tb_if_fetch_stage;
  logic clk = 0;
  logic rst, stall, clear_ifid, imem_ready, imem_req, ifid_valid;
  logic [1:0] pc_src;
  logic [31:0] branch_target, jump_target, imem_addr, imem_rdata, ifid_instr, ifid_pc_plus4;
  int vecs = 0;
  int miss = 0;
  logic [31:0] m_pc, m_tgt, e_instr, e_pc4;
  logic m_drain, e_valid;
  logic [63:0] bufq[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = memw(imem_addr);

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src), .clear_ifid(clear_ifid),
    .branch_target(branch_target), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic [1:0] ps, input logic c,
                     input logic [31:0] b, input logic [31:0] j, input logic rd);
    logic redir, give;
    logic [31:0] t;
    logic [63:0] w;
    rst = r; stall = s; pc_src = ps; clear_ifid = c;
    branch_target = b; jump_target = j; imem_ready = rd;
    #1;
    chk("req", {31'b0, imem_req}, {31'b0, !r && bufq.size() == 0});
    if (!r && bufq.size() == 0) chk("addr", imem_addr, m_pc);
    @(posedge clk);
    redir = ps == 2'b01 || ps == 2'b10;
    t = ps == 2'b10 ? j : b;
    give = 0;
    w = '0;
    if (r) begin
      m_pc = 32'h0; m_drain = 0; bufq.delete();
      e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 0;
    end else begin
      if (bufq.size() != 0) begin
        if (redir) begin bufq.delete(); m_pc = t; end
        else if (!s) begin w = bufq.pop_front(); give = 1; end
      end else if (m_drain) begin
        if (redir) m_tgt = t;
        if (rd) begin m_pc = m_tgt; m_drain = 0; end
      end else if (rd) begin
        if (redir) m_pc = t;
        else begin
          w = {memw(m_pc), m_pc + 32'd4};
          m_pc = m_pc + 32'd4;
          if (s) bufq.push_back(w); else give = 1;
        end
      end else if (redir) begin
        m_drain = 1; m_tgt = t;
      end
      if (c) begin e_instr = 32'h0; e_valid = 0; end
      else if (!s) begin
        e_valid = give;
        e_instr = give ? w[63:32] : 32'h0;
        if (give) e_pc4 = w[31:0];
      end
    end
    #1;
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e_valid});
    chk("ifid_instr", ifid_instr, e_instr);
    if (e_valid || r) chk("ifid_pc_plus4", ifid_pc_plus4, e_pc4);
  endtask

  initial begin
    m_pc = 0; m_tgt = 0; m_drain = 0; e_instr = 0; e_pc4 = 0; e_valid = 0;
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("t1_first_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t1_pc4", ifid_pc_plus4, 32'h8);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t2_addr_held", imem_addr, 32'h8);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t2_pc4", ifid_pc_plus4, 32'hC);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 1);
    chk("t3_req_buf", {31'b0, imem_req}, 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t3_pc4", ifid_pc_plus4, 32'h14);
    chk("t3_next_addr", imem_addr, 32'h14);
    cyc(0, 0, 2'b01, 1, 32'h40, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t4_addr_held", imem_addr, 32'h14);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t4_addr_target", imem_addr, 32'h40);
    cyc(0, 0, 2'b10, 1, 0, 32'h100, 1);
    chk("t5_addr", imem_addr, 32'h100);
    cyc(0, 0, 2'b01, 0, 32'h200, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("t6_drain_addr", imem_addr, 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0, 1);
    chk("t6_buf_valid", {31'b0, ifid_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 3) == 0, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
          $urandom_range(0, 2) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
